// File: rtl/cache_request_issuer.sv
// cache_request_issuer: requester-side endpoint of the cache bank access
// protocol. Queues core loads/stores, drives them onto the network link one
// at a time, waits for the matching read response, and retries a bounded
// number of times before reporting an error back to the core.
module cache_request_issuer #(
  parameter int DATA_WIDTH               = 32,
  parameter int CACHE_BANK_ADDRESS_WIDTH = 8,
  parameter int NETWORK_ADDRESS_WIDTH    = 4,
  parameter logic [NETWORK_ADDRESS_WIDTH-1:0] MY_ADDR = 4'h5,
  parameter int QUEUE_DEPTH              = 4,
  parameter int TIMEOUT                  = 16,
  parameter int MAX_RETRY                = 2
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                req_valid,
  output logic                                req_ready,
  input  logic                                req_write,
  input  logic [CACHE_BANK_ADDRESS_WIDTH-1:0] req_bank_addr,
  input  logic [NETWORK_ADDRESS_WIDTH-1:0]    req_dest,
  input  logic [DATA_WIDTH-1:0]               req_wdata,
  output logic                                rsp_valid,
  output logic [DATA_WIDTH-1:0]               rsp_rdata,
  output logic                                rsp_error,
  output logic                                busy,
  output logic [CACHE_BANK_ADDRESS_WIDTH-1:0] cacheAddressOut,
  output logic [NETWORK_ADDRESS_WIDTH-1:0]    destAddressOut,
  output logic [NETWORK_ADDRESS_WIDTH-1:0]    requesterAddressOut,
  output logic                                memReadOut,
  output logic                                memWriteOut,
  output logic [DATA_WIDTH-1:0]               dataOut,
  input  logic                                net_ready,
  input  logic                                readReadyIn,
  input  logic [NETWORK_ADDRESS_WIDTH-1:0]    requesterAddressIn,
  input  logic [DATA_WIDTH-1:0]               dataIn
);

  localparam int PTR_W   = $clog2(QUEUE_DEPTH);
  localparam int TIMER_W = $clog2(TIMEOUT);
  localparam int RETRY_W = $clog2(MAX_RETRY + 2);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP} state_t;

  typedef struct packed {
    logic                                write;
    logic [CACHE_BANK_ADDRESS_WIDTH-1:0] bank;
    logic [NETWORK_ADDRESS_WIDTH-1:0]    dest;
    logic [DATA_WIDTH-1:0]               data;
  } entry_t;

  entry_t             fifo_mem [QUEUE_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W:0]     count;
  logic               empty;
  logic               push;
  entry_t             head;

  state_t             state;
  state_t             next_state;
  logic [TIMER_W-1:0] timer;
  logic [RETRY_W-1:0] retry_count;

  logic               do_pop;
  logic               do_accept;
  logic               do_retry;
  logic               do_match;
  logic               do_error;
  logic               rsp_match;

  assign empty               = (count == '0);
  assign req_ready           = (count != (PTR_W+1)'(QUEUE_DEPTH));
  assign push                = req_valid && req_ready;
  assign head                = fifo_mem[rd_ptr];
  assign busy                = (state != IDLE) || !empty;
  assign requesterAddressOut = MY_ADDR;
  assign rsp_match           = readReadyIn && (requesterAddressIn == MY_ADDR);

  // Request storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= '{write: req_write, bank: req_bank_addr,
                            dest: req_dest, data: req_wdata};
    end
  end

  // FIFO pointers and occupancy; a pop and push in the same cycle keep count.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic and one-cycle action strobes for the datapath.
  always_comb begin
    next_state = state;
    do_pop     = 1'b0;
    do_accept  = 1'b0;
    do_retry   = 1'b0;
    do_match   = 1'b0;
    do_error   = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          do_pop     = 1'b1;
          next_state = ISSUE;
        end
      end
      ISSUE: begin
        if (net_ready) begin
          do_accept  = 1'b1;
          next_state = memWriteOut ? IDLE : WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        if (rsp_match) begin
          do_match   = 1'b1;
          next_state = IDLE;
        end else if (timer == TIMER_W'(TIMEOUT - 1)) begin
          if (retry_count < RETRY_W'(MAX_RETRY)) begin
            do_retry   = 1'b1;
            next_state = ISSUE;
          end else begin
            do_error   = 1'b1;
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Response timer runs only while staying in WAIT_RSP; retry count spans one load.
  always_ff @(posedge clk) begin
    if (reset) begin
      timer       <= '0;
      retry_count <= '0;
    end else begin
      if (state == WAIT_RSP && next_state == WAIT_RSP) timer <= timer + TIMER_W'(1);
      else                                              timer <= '0;
      if (do_match || do_error) retry_count <= '0;
      else if (do_retry)        retry_count <= retry_count + RETRY_W'(1);
    end
  end

  // Link-side request registers and core-side response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cacheAddressOut <= '0;
      destAddressOut  <= '0;
      dataOut         <= '0;
      memReadOut      <= 1'b0;
      memWriteOut     <= 1'b0;
      rsp_valid       <= 1'b0;
      rsp_error       <= 1'b0;
      rsp_rdata       <= '0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_error <= 1'b0;
      if (do_pop) begin
        cacheAddressOut <= head.bank;
        destAddressOut  <= head.dest;
        dataOut         <= head.data;
        memWriteOut     <= head.write;
        memReadOut      <= !head.write;
      end
      if (do_accept) begin
        memReadOut  <= 1'b0;
        memWriteOut <= 1'b0;
      end
      if (do_retry) memReadOut <= 1'b1;
      if (do_match) begin
        rsp_valid <= 1'b1;
        rsp_rdata <= dataIn;
      end
      if (do_error) begin
        rsp_valid <= 1'b1;
        rsp_error <= 1'b1;
        rsp_rdata <= '0;
      end
    end
  end

endmodule

// File: tb/tb_cache_request_issuer.sv
// Directed self-checking bench for cache_request_issuer.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_cache_request_issuer;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [7:0]  req_bank_addr;
  logic [3:0]  req_dest;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        busy;
  logic [7:0]  cacheAddressOut;
  logic [3:0]  destAddressOut;
  logic [3:0]  requesterAddressOut;
  logic        memReadOut;
  logic        memWriteOut;
  logic [31:0] dataOut;
  logic        net_ready;
  logic        readReadyIn;
  logic [3:0]  requesterAddressIn;
  logic [31:0] dataIn;

  int testsRun    = 0;
  int testsFailed = 0;

  cache_request_issuer dut (
    .clk                 (clk),
    .reset               (reset),
    .req_valid           (req_valid),
    .req_ready           (req_ready),
    .req_write           (req_write),
    .req_bank_addr       (req_bank_addr),
    .req_dest            (req_dest),
    .req_wdata           (req_wdata),
    .rsp_valid           (rsp_valid),
    .rsp_rdata           (rsp_rdata),
    .rsp_error           (rsp_error),
    .busy                (busy),
    .cacheAddressOut     (cacheAddressOut),
    .destAddressOut      (destAddressOut),
    .requesterAddressOut (requesterAddressOut),
    .memReadOut          (memReadOut),
    .memWriteOut         (memWriteOut),
    .dataOut             (dataOut),
    .net_ready           (net_ready),
    .readReadyIn         (readReadyIn),
    .requesterAddressIn  (requesterAddressIn),
    .dataIn              (dataIn)
  );

  always #5 clk = ~clk;

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Present one request for exactly one clock edge.
  task automatic applyStimulus(input logic write, input logic [7:0] bank,
                               input logic [3:0] dest, input logic [31:0] data);
    req_valid     = 1'b1;
    req_write     = write;
    req_bank_addr = bank;
    req_dest      = dest;
    req_wdata     = data;
    stepClock();
    req_valid = 1'b0;
  endtask

  task automatic sendResponse(input logic [3:0] addr, input logic [31:0] data);
    readReadyIn        = 1'b1;
    requesterAddressIn = addr;
    dataIn             = data;
    stepClock();
    readReadyIn = 1'b0;
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_bank_addr = '0;
    req_dest = '0; req_wdata = '0; net_ready = 1'b0; readReadyIn = 1'b0;
    requesterAddressIn = '0; dataIn = '0;
    #1;
    stepClock();
    stepClock();
    reset = 1'b0;

    // Reset state
    checkOutput("rst req_ready", req_ready, 1);
    checkOutput("rst memRead", memReadOut, 0);
    checkOutput("rst memWrite", memWriteOut, 0);
    checkOutput("rst requester", requesterAddressOut, 4'h5);
    checkOutput("rst rsp_valid", rsp_valid, 0);
    checkOutput("rst busy", busy, 0);
    checkOutput("rst cacheAddr", cacheAddressOut, 0);

    // 1: single store
    net_ready = 1'b1;
    applyStimulus(1'b1, 8'h12, 4'h3, 32'hDEADBEEF);
    checkOutput("t1 write before pop", memWriteOut, 0);
    stepClock();
    checkOutput("t1 memWrite", memWriteOut, 1);
    checkOutput("t1 memRead", memReadOut, 0);
    checkOutput("t1 cacheAddr", cacheAddressOut, 8'h12);
    checkOutput("t1 dest", destAddressOut, 4'h3);
    checkOutput("t1 data", dataOut, 32'hDEADBEEF);
    checkOutput("t1 requester", requesterAddressOut, 4'h5);
    stepClock();
    checkOutput("t1 write drop", memWriteOut, 0);
    checkOutput("t1 no rsp", rsp_valid, 0);
    checkOutput("t1 idle", busy, 0);
    stepClock();
    checkOutput("t1 no rsp later", rsp_valid, 0);

    // 2: load with response 3 cycles after acceptance
    applyStimulus(1'b0, 8'h40, 4'h1, 32'h0);
    stepClock();
    checkOutput("t2 memRead", memReadOut, 1);
    checkOutput("t2 cacheAddr", cacheAddressOut, 8'h40);
    stepClock();
    checkOutput("t2 read drop", memReadOut, 0);
    checkOutput("t2 busy wait", busy, 1);
    stepClock();
    stepClock();
    sendResponse(4'h5, 32'hCAFE0001);
    checkOutput("t2 rsp_valid", rsp_valid, 1);
    checkOutput("t2 rsp_rdata", rsp_rdata, 32'hCAFE0001);
    checkOutput("t2 rsp_error", rsp_error, 0);
    checkOutput("t2 busy fall", busy, 0);
    stepClock();
    checkOutput("t2 pulse end", rsp_valid, 0);
    checkOutput("t2 rdata hold", rsp_rdata, 32'hCAFE0001);

    // 3: backpressure fills issue register plus FIFO, then drains in order
    net_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 8'(i), 4'h7, 32'h100 + i);
      checkOutput($sformatf("t3 ready after push%0d", i), req_ready, (i < 4) ? 1 : 0);
    end
    checkOutput("t3 held write", memWriteOut, 1);
    checkOutput("t3 held addr", cacheAddressOut, 0);
    net_ready = 1'b1;
    stepClock();
    checkOutput("t3 first accepted", memWriteOut, 0);
    for (int k = 1; k < 5; k++) begin
      stepClock();
      checkOutput($sformatf("t3 write%0d", k), memWriteOut, 1);
      checkOutput($sformatf("t3 addr%0d", k), cacheAddressOut, 8'(k));
      checkOutput($sformatf("t3 data%0d", k), dataOut, 32'h100 + k);
      stepClock();
    end
    checkOutput("t3 drained", busy, 0);
    checkOutput("t3 ready back", req_ready, 1);

    // 4: foreign response ignored, own response completes
    applyStimulus(1'b0, 8'h41, 4'h2, 32'h0);
    stepClock();
    stepClock();
    stepClock();
    sendResponse(4'h2, 32'h00000BAD);
    checkOutput("t4 foreign ignored", rsp_valid, 0);
    checkOutput("t4 still busy", busy, 1);
    stepClock();
    sendResponse(4'h5, 32'h12345678);
    checkOutput("t4 rsp_valid", rsp_valid, 1);
    checkOutput("t4 rsp_rdata", rsp_rdata, 32'h12345678);
    checkOutput("t4 rsp_error", rsp_error, 0);

    // 5: no response, two reissues then error
    applyStimulus(1'b0, 8'h42, 4'h4, 32'h0);
    stepClock();
    stepClock();
    checkOutput("t5 accepted", memReadOut, 0);
    for (int r = 0; r < 2; r++) begin
      repeat (15) stepClock();
      checkOutput($sformatf("t5 quiet%0d", r), memReadOut, 0);
      stepClock();
      checkOutput($sformatf("t5 reissue%0d", r), memReadOut, 1);
      checkOutput($sformatf("t5 reissue addr%0d", r), cacheAddressOut, 8'h42);
      checkOutput($sformatf("t5 no rsp%0d", r), rsp_valid, 0);
      stepClock();
      checkOutput($sformatf("t5 reaccept%0d", r), memReadOut, 0);
    end
    repeat (15) stepClock();
    checkOutput("t5 before error", rsp_valid, 0);
    stepClock();
    checkOutput("t5 err valid", rsp_valid, 1);
    checkOutput("t5 err flag", rsp_error, 1);
    checkOutput("t5 err rdata", rsp_rdata, 0);
    checkOutput("t5 no third reissue", memReadOut, 0);
    stepClock();
    checkOutput("t5 err pulse end", rsp_valid, 0);
    checkOutput("t5 err flag end", rsp_error, 0);

    // 6: reset during WAIT_RSP with two queued requests
    applyStimulus(1'b0, 8'h43, 4'h6, 32'h0);
    stepClock();
    stepClock();
    applyStimulus(1'b1, 8'h50, 4'h6, 32'hAAAA0000);
    applyStimulus(1'b1, 8'h51, 4'h6, 32'hBBBB0000);
    checkOutput("t6 busy before reset", busy, 1);
    reset = 1'b1;
    stepClock();
    reset = 1'b0;
    checkOutput("t6 busy", busy, 0);
    checkOutput("t6 req_ready", req_ready, 1);
    checkOutput("t6 memRead", memReadOut, 0);
    checkOutput("t6 cacheAddr", cacheAddressOut, 0);
    checkOutput("t6 rsp_rdata", rsp_rdata, 0);
    checkOutput("t6 requester", requesterAddressOut, 4'h5);
    stepClock();
    stepClock();
    checkOutput("t6 no issue write", memWriteOut, 0);
    checkOutput("t6 no issue read", memReadOut, 0);
    sendResponse(4'h5, 32'h77777777);
    checkOutput("t6 late rsp ignored", rsp_valid, 0);
    checkOutput("t6 still idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/cache_request_issuer.md
Name: cache_request_issuer

Overview:
Requester-side endpoint of the cache bank access protocol, located at each core node. It queues load and store requests from the core and drives them onto the network link as bank address, requester address, memRead/memWrite and data. For reads, it waits for the matching readReady response and returns the data to the core. A timeout with bounded retry prevents a lost response from hanging the core.

Parameters:
DATA_WIDTH, 32, read/write data width
CACHE_BANK_ADDRESS_WIDTH, 8, word address inside a cache bank
NETWORK_ADDRESS_WIDTH, 4, router node address width
MY_ADDR, 4'h5, this node's network address; sent as the requester address and matched on responses
QUEUE_DEPTH, 4, request FIFO entries (power of 2)
TIMEOUT, 16, cycles in WAIT_RSP before a retry is triggered (≥2)
MAX_RETRY, 2, re-issues allowed before an error response

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
req_valid  in  1  core request present
req_ready  out  1  FIFO can accept; equals !full
req_write  in  1  1 = store, 0 = load
req_bank_addr  in  CACHE_BANK_ADDRESS_WIDTH  cache bank word address
req_dest  in  NETWORK_ADDRESS_WIDTH  node address of the target bank
req_wdata  in  DATA_WIDTH  store data
rsp_valid  out  1  one-cycle pulse: load completed
rsp_rdata  out  DATA_WIDTH  load data; holds its value until the next rsp_valid
rsp_error  out  1  qualifies rsp_valid; 1 = retries exhausted
busy  out  1  state != IDLE or FIFO non-empty
cacheAddressOut  out  CACHE_BANK_ADDRESS_WIDTH  request bank address
destAddressOut  out  NETWORK_ADDRESS_WIDTH  request destination node
requesterAddressOut  out  NETWORK_ADDRESS_WIDTH  constant MY_ADDR
memReadOut  out  1  read request valid
memWriteOut  out  1  write request valid
dataOut  out  DATA_WIDTH  write data
net_ready  in  1  link accepts the request this cycle
readReadyIn  in  1  response valid from the network
requesterAddressIn  in  NETWORK_ADDRESS_WIDTH  response destination
dataIn  in  DATA_WIDTH  response data

Behaviour:
- Reset (synchronous, on the clk edge while reset=1):
  - FIFO empty; state IDLE; timer = 0; retry count = 0.
  - All outputs 0, except requesterAddressOut = MY_ADDR and req_ready = 1.
- FIFO:
  - Push on req_valid && req_ready. A push when full is impossible, because req_ready = 0 when full, even in a cycle that pops. There is no bypass.
  - Pointers wrap modulo QUEUE_DEPTH. The count is one bit wider than the pointers.
- IDLE: when the FIFO is non-empty, pop the head into the output registers and go to ISSUE. Latency:
  - A request accepted at edge N (empty FIFO, IDLE) pops at edge N+1.
  - memReadOut or memWriteOut is high from edge N+1.
- ISSUE:
  - Exactly one of memReadOut/memWriteOut is high. cacheAddressOut, destAddressOut and dataOut are held stable.
  - The request is accepted at an edge where net_ready = 1. At that edge memReadOut and memWriteOut fall to 0.
  - After an accepted store: go to IDLE. Stores produce no rsp_valid. The next request is issued no earlier than 2 cycles later.
  - After an accepted load: go to WAIT_RSP with timer = 0.
  - net_ready low: stay in ISSUE indefinitely; the timer does not run.
- WAIT_RSP:
  - Match: readReadyIn = 1 and requesterAddressIn == MY_ADDR at an edge. Then rsp_rdata <= dataIn, rsp_valid = 1 for one cycle, rsp_error = 0, retry count = 0, and go to IDLE.
  - readReadyIn with any other requesterAddressIn is ignored, and the timer continues.
  - Otherwise the timer increments. When timer == TIMEOUT-1 (no match):
    - If retry count < MAX_RETRY: increment the retry count, clear the timer, and return to ISSUE with the same held request.
    - Else: rsp_valid = 1, rsp_error = 1, rsp_rdata = 0, retry count = 0, and go to IDLE.
  - A match on the same edge as the timeout wins.
- Responses in IDLE or ISSUE (late or duplicate) are ignored.
- Only one load is outstanding at a time. The FIFO keeps accepting requests while the block waits.
- Reset mid-operation discards the queued requests and any outstanding load. No rsp_valid is generated for them.
- rsp_valid and rsp_error are both 0 in every cycle without a completion.

Test Plan:
1. Store push: bank 8'h12, dest 4'h3, wdata 32'hDEADBEEF, net_ready = 1 -> memWriteOut high for exactly 1 cycle, starting 1 edge after the push, with those values and requesterAddressOut = 4'h5. No rsp_valid.
2. Load: bank 8'h40; net_ready = 1; response (4'h5, 32'hCAFE0001) 3 cycles after acceptance -> rsp_valid for 1 cycle, rsp_rdata = 32'hCAFE0001, rsp_error = 0, busy falls.
3. Backpressure: net_ready = 0; push 5 stores -> req_ready falls after the 5th push (1 in the issue registers + 4 in the FIFO). Release net_ready -> the stores issue in push order.
4. Foreign response: during WAIT_RSP, readReadyIn with requesterAddressIn = 4'h2 -> ignored. A later 4'h5 response completes the load normally.
5. No response: TIMEOUT = 16, MAX_RETRY = 2 -> memReadOut is reissued twice, 16 cycles after each acceptance. On the third timeout: rsp_valid = 1, rsp_error = 1, rsp_rdata = 0.
6. Reset while in WAIT_RSP with 2 requests queued -> all outputs are at reset values on the next cycle and the FIFO is empty. A 4'h5 response arriving after reset produces no rsp_valid.
